// File: rtl/res_net_pkg.sv
// Shared definitions for the resonator-network controller: vector width,
// controller state encoding and default iteration/stability constants.
package res_net_pkg;

    localparam int VECTOR_LEN            = 32;
    localparam int RES_NET_MAX_ITERS     = 64;
    localparam int RES_NET_STABLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_ITER  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/res_net_ctrl.sv
// Query sequencer for the resonator factorizer: clears and seeds the network,
// runs it until all three features converge or the budget runs out, holds the result.
module res_net_ctrl #(
    parameter int VECTOR_LEN    = res_net_pkg::VECTOR_LEN,
    parameter int MAX_ITERS     = res_net_pkg::RES_NET_MAX_ITERS,
    parameter int STABLE_CYCLES = res_net_pkg::RES_NET_STABLE_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_scene_valid,
    output logic                  o_scene_ready,
    input  logic [VECTOR_LEN-1:0] i_scene,
    input  logic                  i_abort,
    output logic                  o_net_rstn,
    output logic                  o_net_init,
    output logic [VECTOR_LEN-1:0] o_net_scene,
    input  logic                  i_color_conv,
    input  logic                  i_shape_conv,
    input  logic                  i_pos_conv,
    input  logic [VECTOR_LEN-1:0] i_color_pred,
    input  logic [VECTOR_LEN-1:0] i_shape_pred,
    input  logic [VECTOR_LEN-1:0] i_pos_pred,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [VECTOR_LEN-1:0] o_res_color,
    output logic [VECTOR_LEN-1:0] o_res_shape,
    output logic [VECTOR_LEN-1:0] o_res_pos,
    output logic                  o_res_converged,
    output logic [15:0]           o_res_iters
);
    import res_net_pkg::*;

    // Handshakes: a query transfers on the edge where i_scene_valid && o_scene_ready;
    // a result transfers on the edge where o_res_valid && i_res_ready. Both valids
    // are held by their producer until the transfer.

    ctrl_state_e           state_q, state_d;
    logic [15:0]           iter_cnt_q, iter_cnt_d;
    logic [15:0]           stable_cnt_q, stable_cnt_d;
    logic [VECTOR_LEN-1:0] scene_q, scene_d;
    logic [VECTOR_LEN-1:0] color_q, color_d, shape_q, shape_d, pos_q, pos_d;
    logic                  converged_q, converged_d;
    logic [15:0]           iters_q, iters_d;
    logic                  res_valid_q, res_valid_d;
    logic                  scene_ready_q, scene_ready_d;
    logic                  net_rstn_q, net_rstn_d;
    logic                  net_init_q, net_init_d;

    logic all3, conv_hit, budget_hit;

    assign all3       = i_color_conv & i_shape_conv & i_pos_conv;
    assign conv_hit   = all3 && (stable_cnt_q == 16'(STABLE_CYCLES - 1));
    assign budget_hit = (iter_cnt_q == 16'(MAX_ITERS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            iter_cnt_q    <= '0;
            stable_cnt_q  <= '0;
            scene_q       <= '0;
            color_q       <= '0;
            shape_q       <= '0;
            pos_q         <= '0;
            converged_q   <= 1'b0;
            iters_q       <= '0;
            res_valid_q   <= 1'b0;
            scene_ready_q <= 1'b0;
            net_rstn_q    <= 1'b0;
            net_init_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_cnt_q    <= iter_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            scene_q       <= scene_d;
            color_q       <= color_d;
            shape_q       <= shape_d;
            pos_q         <= pos_d;
            converged_q   <= converged_d;
            iters_q       <= iters_d;
            res_valid_q   <= res_valid_d;
            scene_ready_q <= scene_ready_d;
            net_rstn_q    <= net_rstn_d;
            net_init_q    <= net_init_d;
        end
    end

    // Convergence is tested before the budget so a tie reports convergence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_scene_valid && scene_ready_q) state_d = ST_CLEAR;
            ST_CLEAR: state_d = i_abort ? ST_IDLE : ST_INIT;
            ST_INIT:  state_d = i_abort ? ST_IDLE : ST_ITER;
            ST_ITER: begin
                if (i_abort)                      state_d = ST_IDLE;
                else if (conv_hit || budget_hit) state_d = ST_DONE;
            end
            ST_DONE:  if (i_res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Network controls are derived from the next state so they are registered
    // yet line up with the cycle the state is actually in.
    always_comb begin
        scene_ready_d = (state_d == ST_IDLE);
        net_rstn_d    = (state_d != ST_CLEAR);
        net_init_d    = (state_d == ST_INIT);
        iter_cnt_d    = iter_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        scene_d       = scene_q;
        color_d       = color_q;
        shape_d       = shape_q;
        pos_d         = pos_q;
        converged_d   = converged_q;
        iters_d       = iters_q;
        res_valid_d   = res_valid_q;

        unique case (state_q)
            ST_IDLE: if (state_d == ST_CLEAR) scene_d = i_scene;
            ST_INIT: begin
                iter_cnt_d   = '0;
                stable_cnt_d = '0;
            end
            ST_ITER: if (!i_abort) begin
                if (iter_cnt_q != 16'hFFFF) iter_cnt_d = iter_cnt_q + 16'd1;
                if (!all3)                                      stable_cnt_d = '0;
                else if (stable_cnt_q != 16'(STABLE_CYCLES))    stable_cnt_d = stable_cnt_q + 16'd1;
                if (state_d == ST_DONE) begin
                    color_d     = i_color_pred;
                    shape_d     = i_shape_pred;
                    pos_d       = i_pos_pred;
                    converged_d = conv_hit;
                    iters_d     = conv_hit ? iter_cnt_q + 16'd1 : 16'(MAX_ITERS);
                    res_valid_d = 1'b1;
                end
            end
            ST_DONE: if (i_res_ready) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign o_scene_ready   = scene_ready_q;
    assign o_net_rstn      = net_rstn_q;
    assign o_net_init      = net_init_q;
    assign o_net_scene     = scene_q;
    assign o_res_valid     = res_valid_q;
    assign o_res_color     = color_q;
    assign o_res_shape     = shape_q;
    assign o_res_pos       = pos_q;
    assign o_res_converged = converged_q;
    assign o_res_iters     = iters_q;

endmodule

// File: tb/tb_res_net_ctrl.sv
// Bench for res_net_ctrl: table of convergence-flag patterns with a result
// scoreboard, plus hand sequences for tie, abort, backpressure and reset.
module tb_res_net_ctrl;
    localparam int VL = res_net_pkg::VECTOR_LEN;
    localparam int RW = 1 + 16 + 3 * VL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scene_valid = 1'b0;
    logic [VL-1:0] scene = '0;
    logic          abort = 1'b0;
    logic          c_conv = 1'b0, s_conv = 1'b0, p_conv = 1'b0;
    logic [VL-1:0] c_pred = '0, s_pred = '0, p_pred = '0;
    logic          res_ready = 1'b0;

    logic          scene_ready, net_rstn, net_init, res_valid, res_conv;
    logic [VL-1:0] net_scene, res_color, res_shape, res_pos;
    logic [15:0]   res_iters;
    logic          b_scene_ready, b_net_rstn, b_net_init, b_res_valid, b_res_conv;
    logic [VL-1:0] b_net_scene, b_res_color, b_res_shape, b_res_pos;
    logic [15:0]   b_res_iters;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    res_net_ctrl #(.MAX_ITERS(8), .STABLE_CYCLES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_scene_valid(scene_valid), .o_scene_ready(scene_ready),
        .i_scene(scene), .i_abort(abort), .o_net_rstn(net_rstn), .o_net_init(net_init),
        .o_net_scene(net_scene), .i_color_conv(c_conv), .i_shape_conv(s_conv), .i_pos_conv(p_conv),
        .i_color_pred(c_pred), .i_shape_pred(s_pred), .i_pos_pred(p_pred),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_color(res_color),
        .o_res_shape(res_shape), .o_res_pos(res_pos), .o_res_converged(res_conv),
        .o_res_iters(res_iters)
    );

    res_net_ctrl #(.MAX_ITERS(4), .STABLE_CYCLES(2)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_scene_valid(scene_valid), .o_scene_ready(b_scene_ready),
        .i_scene(scene), .i_abort(abort), .o_net_rstn(b_net_rstn), .o_net_init(b_net_init),
        .o_net_scene(b_net_scene), .i_color_conv(c_conv), .i_shape_conv(s_conv), .i_pos_conv(p_conv),
        .i_color_pred(c_pred), .i_shape_pred(s_pred), .i_pos_pred(p_pred),
        .o_res_valid(b_res_valid), .i_res_ready(res_ready), .o_res_color(b_res_color),
        .o_res_shape(b_res_shape), .o_res_pos(b_res_pos), .o_res_converged(b_res_conv),
        .o_res_iters(b_res_iters)
    );

    typedef struct {
        logic [31:0] mask;   // bit k-1 = all three flags high on ITER cycle k
        logic        conv;
        int          iters;
        int          hold;   // cycles i_res_ready stays low in DONE
        bit          bp;     // offer a new query while held in DONE
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_flags(input bit all3);
        if (all3) {c_conv, s_conv, p_conv} = 3'b111;
        else      {c_conv, s_conv, p_conv} = 3'($urandom_range(0, 6));
        c_pred = VL'($urandom);
        s_pred = VL'($urandom);
        p_pred = VL'($urandom);
    endtask

    task automatic run_query(input logic [31:0] mask, input logic conv, input int iters,
                             input int hold, input bit bp, input bit chk4);
        logic [VL-1:0] sc;
        logic [RW-1:0] exp_r;
        bit            done;
        int            lat;
        check("ready_before_accept", RW'(scene_ready), RW'(1'b1));
        sc          = VL'($urandom);
        scene       = sc;
        scene_valid = 1'b1;
        tick();
        scene_valid = 1'b0;
        check("clear_rstn", RW'({net_rstn, scene_ready}), RW'(2'b00));
        check("latched_scene", RW'(net_scene), RW'(sc));
        tick();
        check("init_pulse", RW'({net_init, net_rstn}), RW'(2'b11));
        tick();
        check("init_drop", RW'(net_init), RW'(1'b0));
        done = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 32 && !done; c++) begin
            drive_flags(mask[c-1]);
            if (c == iters) exp_q.push_back({conv, 16'(iters), c_pred, s_pred, p_pred});
            tick();
            if (res_valid) begin
                done = 1'b1;
                lat  = c;
            end
        end
        {c_conv, s_conv, p_conv} = 3'b000;
        check("result_arrived", RW'(done), RW'(1'b1));
        if (!done) return;
        check("iter_latency", RW'(lat), RW'(iters));
        exp_r = '0;
        if (exp_q.size() > 0) exp_r = exp_q.pop_front();
        check("result_bundle", {res_conv, res_iters, res_color, res_shape, res_pos}, exp_r);
        if (chk4)
            check("tie_result", RW'({b_res_valid, b_res_conv, b_res_iters}), RW'({2'b11, 16'(iters)}));
        res_ready   = 1'b0;
        scene_valid = bp;
        for (int h = 0; h < hold; h++) begin
            scene = VL'($urandom);
            tick();
            check("hold_state", RW'({res_valid, scene_ready, net_scene}), RW'({2'b10, sc}));
            check("hold_bundle", {res_conv, res_iters, res_color, res_shape, res_pos}, exp_r);
        end
        scene_valid = 1'b0;
        res_ready   = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release", RW'({res_valid, scene_ready}), RW'(2'b01));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("reset_ctrl", RW'({scene_ready, net_rstn, net_init, res_valid, res_conv}), RW'(5'b0));
        check("reset_vecs", {res_iters, res_color, res_shape, res_pos, net_scene[0]},
              RW'({net_scene[0]}) & '0);
        check("reset_scene", RW'(net_scene), RW'(0));
        rst = 1'b0;
        tick();
        check("after_reset", RW'({net_rstn, scene_ready}), RW'(2'b11));
    endtask

    task automatic abort_at(input int stage);
        scene       = VL'($urandom);
        scene_valid = 1'b1;
        tick();
        scene_valid = 1'b0;
        for (int s = 0; s < stage; s++) begin
            drive_flags(1'b0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", RW'({scene_ready, net_rstn, net_init, res_valid}), RW'(4'b1100));
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_result", RW'({res_valid, scene_ready}), RW'(2'b01));
    endtask

    initial begin
        tbl[0] = '{mask: 32'hFFFF_FFF0, conv: 1'b1, iters: 6, hold: 10, bp: 1'b1};
        tbl[1] = '{mask: 32'h0000_0000, conv: 1'b0, iters: 8, hold: 2,  bp: 1'b0};
        tbl[2] = '{mask: 32'h0000_000D, conv: 1'b1, iters: 4, hold: 0,  bp: 1'b0};
        tbl[3] = '{mask: 32'h0000_0055, conv: 1'b0, iters: 8, hold: 1,  bp: 1'b0};
        tbl[4] = '{mask: 32'hFFFF_FFFF, conv: 1'b1, iters: 2, hold: 0,  bp: 1'b0};
        tbl[5] = '{mask: 32'h0000_00C0, conv: 1'b1, iters: 8, hold: 0,  bp: 1'b0};
        tbl[6] = '{mask: 32'h0000_0080, conv: 1'b0, iters: 8, hold: 0,  bp: 1'b0};

        do_reset();
        for (int i = 0; i < 7; i++)
            run_query(tbl[i].mask, tbl[i].conv, tbl[i].iters, tbl[i].hold, tbl[i].bp, 1'b0);

        // Budget of 4 with a second converged cycle on cycle 4: convergence must win.
        do_reset();
        run_query(32'h0000_000C, 1'b1, 4, 0, 1'b0, 1'b1);

        abort_at(3);   // abort on ITER cycle 2
        abort_at(0);   // abort in CLEAR
        abort_at(1);   // abort in INIT

        // Abort while IDLE is ignored: the offered query is still taken.
        scene_valid = 1'b1;
        abort       = 1'b1;
        tick();
        scene_valid = 1'b0;
        abort       = 1'b0;
        check("idle_abort_ignored", RW'({net_rstn, scene_ready}), RW'(2'b00));
        tick();
        tick();
        begin : reach_done
            bit got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                drive_flags(1'b1);
                tick();
                got = res_valid;
            end
            check("reach_done", RW'(got), RW'(1'b1));
        end
        {c_conv, s_conv, p_conv} = 3'b000;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("done_abort_ignored", RW'({res_valid, res_iters}), RW'({1'b1, 16'd2}));
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
